// File: rtl/baggage_pkg.sv
// Shared types and constants for the sequential baggage-drop path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package baggage_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIV,
    ST_SQRT,
    ST_DECIDE,
    ST_HOLD
  } state_t;

  // Index 0 drives seven_seg1, index 3 drives seven_seg4.
  localparam logic [6:0] SEG_BLANK   = 7'b0000000;
  localparam logic [6:0] SEG_DROP [4] = '{7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
  localparam logic [6:0] SEG_HOT  [4] = '{7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000};
  localparam logic [6:0] SEG_COLD [4] = '{7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};

  // Ceiling log2 for elaboration-time width math; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/baggage_isqrt_seq.sv
// Bit-serial non-restoring integer square root, floor(sqrt(radicand)).
// Latency: loads on the load edge, then RAD_W/2 edges; valid pulses with the last bit.
// Backpressure: none; a load while busy restarts the computation.
module baggage_isqrt_seq
  import baggage_pkg::*;
#(
  parameter int RAD_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [RAD_W-1:0]   radicand,
  output logic               busy,
  output logic [RAD_W/2-1:0] root,
  output logic               valid
);

  localparam int ROOT_W = RAD_W / 2;
  // Remainder magnitude stays below 2^(ROOT_W+1); two more bits absorb the <<2.
  localparam int REM_W  = ROOT_W + 4;
  localparam int CNT_W  = clog2(ROOT_W + 1);

  logic [RAD_W-1:0]  rad_q, rad_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic [REM_W-1:0]  shifted_c;

  // One root bit per cycle: remainder may go negative and is corrected on the next step.
  always_comb begin
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    shifted_c = (rem_q << 2) | REM_W'(rad_q[RAD_W-1 -: 2]);
    if (load) begin
      rad_d  = radicand;
      rem_d  = '0;
      root_d = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rad_d = rad_q << 2;
      if (!rem_q[REM_W-1]) rem_d = shifted_c - REM_W'({root_q, 2'b01});
      else                 rem_d = shifted_c + REM_W'({root_q, 2'b11});
      root_d = {root_q[ROOT_W-2:0], ~rem_d[REM_W-1]};
      cnt_d  = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(ROOT_W - 1)) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy  = busy_q;
  assign root  = root_q;
  assign valid = valid_q;

endmodule

// File: rtl/baggage_drop_seq.sv
// Sensor averaging, bit-serial divide and root, t_lim decision, 7-seg display and drop hold.
// Latency: done SUM_W + ROOT_W + 1 edges after start is accepted (23 with defaults).
// Backpressure: start is only sampled while busy=0; starts during busy are dropped.
module baggage_drop_seq
  import baggage_pkg::*;
#(
  parameter int N_SENSORS  = 4,
  parameter int SENSOR_W   = 8,
  parameter int FRAC_SHIFT = 16,
  parameter int T_W        = 16,
  parameter int DROP_HOLD  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_SENSORS*SENSOR_W-1:0] sensors,
  input  logic [T_W-1:0]                t_lim,
  input  logic                          drop_en,
  output logic                          busy,
  output logic                          done,
  output logic [T_W-1:0]                t_act,
  output logic [6:0]                    seven_seg1,
  output logic [6:0]                    seven_seg2,
  output logic [6:0]                    seven_seg3,
  output logic [6:0]                    seven_seg4,
  output logic                          drop_activated
);

  localparam int SUM_W  = SENSOR_W + clog2(N_SENSORS);
  localparam int RAD_W  = SENSOR_W + FRAC_SHIFT;
  localparam int ROOT_W = RAD_W / 2;
  localparam int STEP_W = clog2((SUM_W > ROOT_W ? SUM_W : ROOT_W) + 1);
  localparam int HOLD_W = clog2(DROP_HOLD + 1);
  localparam logic [SUM_W-1:0] H_MAX = SUM_W'({SENSOR_W{1'b1}});

  state_t            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [SUM_W-1:0]  dvd_q, dvd_d;      // dividend shifts out, quotient shifts in
  logic [SUM_W-1:0]  rem_q, rem_d;
  logic [SUM_W-1:0]  cnt_q, cnt_d;
  logic [T_W-1:0]    t_lim_q, t_lim_d;
  logic              drop_en_q, drop_en_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [T_W-1:0]    t_act_q, t_act_d;
  logic              drop_q, drop_d;
  logic [6:0]        seg_q [4];
  logic [6:0]        seg_d [4];

  logic [SUM_W-1:0]  sum_c, cnt_c;
  logic [SUM_W:0]    trial_c;
  logic              q_bit_c;
  logic [SUM_W-1:0]  quot_c;
  logic [SENSOR_W-1:0] height_c;
  logic [RAD_W-1:0]  radicand_c;
  logic [T_W-1:0]    tact_c;
  logic              sqrt_load, sqrt_busy, sqrt_valid;
  logic [ROOT_W-1:0] sqrt_root;

  // Sum and count of the non-zero channels of the current snapshot.
  always_comb begin
    sum_c = '0;
    cnt_c = '0;
    for (int k = 0; k < N_SENSORS; k++) begin
      sum_c = sum_c + SUM_W'(sensors[k*SENSOR_W +: SENSOR_W]);
      if (sensors[k*SENSOR_W +: SENSOR_W] != '0) cnt_c = cnt_c + SUM_W'(1);
    end
  end

  // Restoring divide step; on the final step the full quotient feeds the root as height.
  always_comb begin
    trial_c    = {rem_q, dvd_q[SUM_W-1]};
    q_bit_c    = (trial_c >= {1'b0, cnt_q});
    quot_c     = {dvd_q[SUM_W-2:0], q_bit_c};
    height_c   = (cnt_q == '0) ? '0 : (quot_c > H_MAX) ? '1 : quot_c[SENSOR_W-1:0];
    radicand_c = RAD_W'(height_c) << FRAC_SHIFT;
    tact_c     = T_W'(sqrt_root >> 1);
  end

  baggage_isqrt_seq #(.RAD_W(RAD_W)) u_isqrt (
    .clk      (clk),
    .rst      (rst),
    .load     (sqrt_load),
    .radicand (radicand_c),
    .busy     (sqrt_busy),
    .root     (sqrt_root),
    .valid    (sqrt_valid)
  );

  // Sequencer next-state: capture, divide, root, decide, then optional drop hold.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    t_lim_d   = t_lim_q;
    drop_en_d = drop_en_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    t_act_d   = t_act_q;
    drop_d    = drop_q;
    seg_d     = seg_q;
    sqrt_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d     = sum_c + (cnt_c >> 1);
          rem_d     = '0;
          cnt_d     = cnt_c;
          t_lim_d   = t_lim;
          drop_en_d = drop_en;
          step_d    = '0;
          busy_d    = 1'b1;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        dvd_d  = quot_c;
        rem_d  = q_bit_c ? SUM_W'(trial_c - {1'b0, cnt_q}) : SUM_W'(trial_c);
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(SUM_W - 1)) begin
          step_d    = '0;
          sqrt_load = 1'b1;
          state_d   = ST_SQRT;
        end
      end
      ST_SQRT: begin
        if (sqrt_busy) begin
          step_d = step_q + STEP_W'(1);
          if (step_q == STEP_W'(ROOT_W - 1)) begin
            step_d  = '0;
            state_d = ST_DECIDE;
          end
        end
      end
      ST_DECIDE: begin
        if (sqrt_valid) begin
          t_act_d = tact_c;
          done_d  = 1'b1;
          if (drop_en_q && (tact_c < t_lim_q)) begin
            seg_d   = SEG_DROP;
            drop_d  = 1'b1;
            hold_d  = HOLD_W'(DROP_HOLD);
            state_d = ST_HOLD;
          end else begin
            drop_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (drop_en_q && (tact_c > t_lim_q))       seg_d = SEG_HOT;
            else if (!drop_en_q && (tact_c < t_lim_q)) seg_d = SEG_COLD;
            else                                       seg_d = '{default: SEG_BLANK};
          end
        end
      end
      ST_HOLD: begin
        // The DECIDE edge counts as the first hold cycle.
        if (hold_q <= HOLD_W'(1)) begin
          drop_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any measurement in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      t_lim_q   <= '0;
      drop_en_q <= 1'b0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      t_act_q   <= '0;
      drop_q    <= 1'b0;
      seg_q     <= '{default: SEG_BLANK};
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      t_lim_q   <= t_lim_d;
      drop_en_q <= drop_en_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      t_act_q   <= t_act_d;
      drop_q    <= drop_d;
      seg_q     <= seg_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign t_act          = t_act_q;
  assign drop_activated = drop_q;
  assign seven_seg1     = seg_q[0];
  assign seven_seg2     = seg_q[1];
  assign seven_seg3     = seg_q[2];
  assign seven_seg4     = seg_q[3];

endmodule

// File: tb/tb_baggage_drop_seq.sv
// Scoreboard bench for baggage_drop_seq with directed vectors.
// Latency: expects done 23 edges after the accepting edge.
// Backpressure: stimulus waits for busy=0 before issuing a start.
module tb_baggage_drop_seq;

  localparam int LAT       = 23;
  localparam int DROP_HOLD = 8;

  localparam logic [27:0] E_DROP  = {7'b1011110, 7'b1010000, 7'b1011100, 7'b1110011};
  localparam logic [27:0] E_HOT   = {7'b0000000, 7'b1110110, 7'b1011100, 7'b1111000};
  localparam logic [27:0] E_COLD  = {7'b0111001, 7'b1011100, 7'b0111000, 7'b1011110};
  localparam logic [27:0] E_BLANK = 28'd0;

  typedef struct {
    int          cyc;
    logic [15:0] t;
    logic [27:0] seg;
    logic        drop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] sensors = '0;
  logic [15:0] t_lim = '0;
  logic        drop_en = 1'b0;
  logic        busy, done, drop_activated;
  logic [15:0] t_act;
  logic [6:0]  seg1, seg2, seg3, seg4;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  baggage_drop_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .sensors        (sensors),
    .t_lim          (t_lim),
    .drop_en        (drop_en),
    .busy           (busy),
    .done           (done),
    .t_act          (t_act),
    .seven_seg1     (seg1),
    .seven_seg2     (seg2),
    .seven_seg3     (seg3),
    .seven_seg4     (seg4),
    .drop_activated (drop_activated)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mk(input int a, input int b, input int c, input int d);
    logic [31:0] v;
    v = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return v;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_t_act"}, int'(t_act), 0);
    check({tag, "_segs"}, int'({seg1, seg2, seg3, seg4}), 0);
    check({tag, "_drop"}, int'(drop_activated), 0);
  endtask

  // Waits for idle, pulses start for one edge, then records the expected response.
  task automatic issue(input logic [31:0] s, input logic [15:0] tl, input logic de,
                       input logic [15:0] et, input logic [27:0] es, input logic ed,
                       input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("issue_wait_idle", int'(busy), 0);
    sensors = s;
    t_lim   = tl;
    drop_en = de;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    if (push) sb.push_back('{cyc + LAT, et, es, ed});
  endtask

  // Monitor: every done pops one expectation; DROP results also get their hold measured.
  initial begin : monitor
    exp_t e;
    int   n;
    forever begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("t_act", int'(t_act), int'(e.t));
          check("segments", int'({seg1, seg2, seg3, seg4}), int'(e.seg));
          check("drop_at_done", int'(drop_activated), int'(e.drop));
          if (e.drop) begin
            n = 0;
            while (drop_activated && n < 100) begin
              n++;
              @(negedge clk);
            end
            check("hold_cycles", n, DROP_HOLD);
            check("busy_falls_with_drop", int'(busy), 0);
          end
        end
      end
    end
  end

  initial begin : stimulus
    int n;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // DROP: avg 100, t_act 1280 < 2000.
    issue(mk(100, 100, 100, 100), 16'd2000, 1'b1, 16'd1280, E_DROP, 1'b1, 1'b1);

    // HOT: start held through HOLD, including the edge busy falls; accepted one edge later.
    n = 0;
    while (!drop_activated && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!drop_activated) check("wait_hold", 0, 1);
    sensors = mk(0, 50, 0, 51);
    t_lim   = 16'd100;
    drop_en = 1'b1;
    start   = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    start = 1'b0;
    check("busy_after_late_start", int'(busy), 1);
    sb.push_back('{cyc + LAT, 16'd914, E_HOT, 1'b0});

    // COLD: avg 41/4 rounds to 10, t_act 404; a start pulse during DIV must be ignored.
    issue(mk(10, 11, 10, 10), 16'hFFFF, 1'b0, 16'd404, E_COLD, 1'b0, 1'b1);
    @(negedge clk);
    sensors = mk(200, 200, 200, 200);
    t_lim   = 16'd1;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset during SQRT: outputs clear, no done for the aborted request.
    issue(mk(100, 100, 100, 100), 16'd2000, 1'b1, 16'd0, E_BLANK, 1'b0, 1'b0);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_reset");
    rst = 1'b0;

    // All channels invalid: t_act 0 equals t_lim 0, blank digits.
    issue(mk(0, 0, 0, 0), 16'd0, 1'b1, 16'd0, E_BLANK, 1'b0, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 0);
    repeat (30) @(negedge clk);
    check("done_count", done_cnt, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
